// File: rtl/muldiv_ctrl_pkg.sv
// rtl/muldiv_ctrl_pkg.sv - shared types, funct codes and FSM states for the mul/div unit
package types;

    localparam int WIDTH   = 32;
    localparam int LOGSIZE = $clog2(WIDTH);

    // Bit 0 is the MSB throughout the datapath.
    typedef logic [0:WIDTH-1]   bus_type;
    typedef logic [0:LOGSIZE-1] bus_logsize_type;
    typedef logic [0:5]         funct_type;

    localparam funct_type FUNC_MTHI  = 6'h11;
    localparam funct_type FUNC_MTLO  = 6'h13;
    localparam funct_type FUNC_MULT  = 6'h18;
    localparam funct_type FUNC_MULTU = 6'h19;
    localparam funct_type FUNC_DIV   = 6'h1a;
    localparam funct_type FUNC_DIVU  = 6'h1b;
    localparam funct_type FUNC_ADD   = 6'h20;

    typedef enum logic [1:0] {
        IDLE,
        PREP,
        RUN,
        FIX
    } muldiv_state_type;

    // Operations that occupy the iterative datapath.
    function automatic logic is_muldiv(funct_type f);
        return (f == FUNC_MULT) || (f == FUNC_MULTU) ||
               (f == FUNC_DIV)  || (f == FUNC_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_ctrl_step.sv
// rtl/muldiv_ctrl_step.sv - one shift-add multiply or restoring divide iteration
module muldiv_step
    import types::*;
#(
    parameter int WIDTH = types::WIDTH
) (
    input  logic             div_mode,
    input  logic [0:WIDTH-1] hi_in,
    input  logic [0:WIDTH-1] lo_in,
    input  logic [0:WIDTH-1] operand,
    output logic [0:WIDTH-1] hi_out,
    output logic [0:WIDTH-1] lo_out
);

    logic [0:WIDTH]   sum;
    logic [0:WIDTH]   shifted;
    logic             ge;

    // Multiply: add operand when the multiplier LSB is set, then shift {hi,lo} right.
    // Divide: shift the next dividend bit into the partial remainder, subtract if it fits.
    always_comb begin
        sum     = {1'b0, hi_in} + (lo_in[WIDTH-1] ? {1'b0, operand} : '0);
        shifted = {hi_in, lo_in[0]};
        ge      = (shifted >= {1'b0, operand});
        if (div_mode) begin
            hi_out = ge ? (shifted[1:WIDTH] - operand) : shifted[1:WIDTH];
            lo_out = {lo_in[1:WIDTH-1], ge};
        end else begin
            hi_out = sum[0:WIDTH-1];
            lo_out = {sum[WIDTH], lo_in[0:WIDTH-2]};
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - iterative HI/LO multiply/divide unit with flush and MTHI/MTLO
module muldiv_ctrl
    import types::*;
#(
    parameter int WIDTH = types::WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  funct_type        funct,
    input  logic [0:WIDTH-1] op_a,
    input  logic [0:WIDTH-1] op_b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             illegal,
    output logic [0:WIDTH-1] hi,
    output logic [0:WIDTH-1] lo
);

    muldiv_state_type state, next_state;

    funct_type        funct_q;
    logic [0:WIDTH-1] a_q, b_q, mag_b, p_hi, p_lo, step_hi, step_lo;
    logic [0:WIDTH-1] res_hi, res_lo;
    logic [0:2*WIDTH-1] prod;
    bus_logsize_type  count;
    logic             neg_res, neg_rem, div_zero;
    logic             is_div, is_signed, accept, fix_commit, legal;

    assign is_div     = (funct_q == FUNC_DIV) || (funct_q == FUNC_DIVU);
    assign is_signed  = (funct_q == FUNC_MULT) || (funct_q == FUNC_DIV);
    assign accept     = (state == IDLE) && start && !flush;
    assign legal      = is_muldiv(funct) || (funct == FUNC_MTHI) || (funct == FUNC_MTLO);
    assign fix_commit = (state == FIX) && !flush;
    assign busy       = (state != IDLE);

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .div_mode (is_div),
        .hi_in    (p_hi),
        .lo_in    (p_lo),
        .operand  (mag_b),
        .hi_out   (step_hi),
        .lo_out   (step_lo)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state: divide-by-zero bypasses RUN; flush wins over everything.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (accept && is_muldiv(funct)) next_state = PREP;
            PREP: next_state = (is_div && (b_q == '0)) ? FIX : RUN;
            RUN:  if (count == bus_logsize_type'(WIDTH-1)) next_state = FIX;
            FIX:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (flush) next_state = IDLE;
    end

    // Sign correction of the unsigned result, applied while in FIX.
    always_comb begin
        prod = {p_hi, p_lo};
        if (neg_res) prod = -prod;
        if (div_zero) begin
            res_hi = a_q;
            res_lo = '1;
        end else if (is_div) begin
            res_hi = neg_rem ? -p_hi : p_hi;
            res_lo = neg_res ? -p_lo : p_lo;
        end else begin
            res_hi = prod[0:WIDTH-1];
            res_lo = prod[WIDTH:2*WIDTH-1];
        end
    end

    // Operand latch, iteration registers and architectural HI/LO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            funct_q  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            mag_b    <= '0;
            p_hi     <= '0;
            p_lo     <= '0;
            count    <= '0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            done    <= fix_commit;
            illegal <= accept && !legal;
            if (accept && (funct == FUNC_MTHI)) hi <= op_a;
            if (accept && (funct == FUNC_MTLO)) lo <= op_a;
            if (accept && is_muldiv(funct)) begin
                funct_q <= funct;
                a_q     <= op_a;
                b_q     <= op_b;
            end
            if (state == PREP) begin
                p_hi     <= '0;
                p_lo     <= (is_signed && a_q[0]) ? -a_q : a_q;
                mag_b    <= (is_signed && b_q[0]) ? -b_q : b_q;
                neg_res  <= is_signed && (a_q[0] ^ b_q[0]);
                neg_rem  <= is_signed && a_q[0];
                div_zero <= is_div && (b_q == '0);
                count    <= '0;
            end
            if (state == RUN) begin
                p_hi  <= step_hi;
                p_lo  <= step_lo;
                count <= count + 1'b1;
            end
            if (fix_commit) begin
                hi <= res_hi;
                lo <= res_lo;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - directed table-driven bench for muldiv_ctrl
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, start, flush;
    logic [5:0]  funct;
    logic [31:0] op_a, op_b;
    logic        busy, done, illegal;
    logic [31:0] hi, lo;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    muldiv_ctrl dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .funct   (funct),
        .op_a    (op_a),
        .op_b    (op_b),
        .flush   (flush),
        .busy    (busy),
        .done    (done),
        .illegal (illegal),
        .hi      (hi),
        .lo      (lo)
    );

    typedef struct {
        string       name;
        logic [5:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          exp_cyc;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue an op, return the edge index (start edge = 0) at which done was seen.
    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          output int cyc);
        start = 1'b1; funct = f; op_a = a; op_b = b;
        tick();
        start = 1'b0;
        cyc = -1;
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (done) begin
                cyc = k;
                break;
            end
        end
    endtask

    int cyc;
    logic seen_done;

    initial begin
        vecs[0] = '{"mult_neg1x2",   6'h18, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 34};
        vecs[1] = '{"multu_ffx2",    6'h19, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 34};
        vecs[2] = '{"div_m7_2",      6'h1a, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 34};
        vecs[3] = '{"divu_100_7",    6'h1b, 32'd100,      32'd7,        32'd2,        32'd14,       34};
        vecs[4] = '{"divu_7_0",      6'h1b, 32'd7,        32'd0,        32'd7,        32'hFFFFFFFF, 2};
        vecs[5] = '{"div_min_m1",    6'h1a, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 34};
        vecs[6] = '{"div_7_m2",      6'h1a, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 34};
        vecs[7] = '{"multu_max_sq",  6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 34};
        vecs[8] = '{"mult_min_sq",   6'h18, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 34};
        vecs[9] = '{"div_neg_by_0",  6'h1a, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 2};

        rst_n = 1'b0; start = 1'b0; flush = 1'b0; funct = '0; op_a = '0; op_b = '0;
        #12;
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_done", {31'b0, done}, 32'd0);
        chk("reset_illegal", {31'b0, illegal}, 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].f, vecs[i].a, vecs[i].b, cyc);
            chk({vecs[i].name, "_cyc"}, 32'(cyc), 32'(vecs[i].exp_cyc));
            chk({vecs[i].name, "_hi"}, hi, vecs[i].exp_hi);
            chk({vecs[i].name, "_lo"}, lo, vecs[i].exp_lo);
            tick();
            chk({vecs[i].name, "_done_pulse"}, {31'b0, done}, 32'd0);
            chk({vecs[i].name, "_idle"}, {31'b0, busy}, 32'd0);
        end

        // MTLO in IDLE
        start = 1'b1; funct = 6'h13; op_a = 32'hCAFEBABE;
        tick();
        start = 1'b0;
        chk("mtlo_lo", lo, 32'hCAFEBABE);
        chk("mtlo_busy", {31'b0, busy}, 32'd0);
        chk("mtlo_no_done", {31'b0, done}, 32'd0);

        // Start with flush in IDLE is ignored
        start = 1'b1; funct = 6'h13; op_a = 32'h11111111; flush = 1'b1;
        tick();
        start = 1'b0; flush = 1'b0;
        chk("start_flush_lo", lo, 32'hCAFEBABE);

        // Illegal funct
        start = 1'b1; funct = 6'h20; op_a = 32'h5;
        tick();
        start = 1'b0;
        chk("illegal_pulse", {31'b0, illegal}, 32'd1);
        chk("illegal_busy", {31'b0, busy}, 32'd0);
        tick();
        chk("illegal_drop", {31'b0, illegal}, 32'd0);

        // Flush during RUN leaves HI/LO untouched
        start = 1'b1; funct = 6'h11; op_a = 32'h12345678;
        tick();
        funct = 6'h13;
        tick();
        start = 1'b0;
        start = 1'b1; funct = 6'h18; op_a = 32'h3; op_b = 32'h5;
        tick();
        start = 1'b0;
        for (int k = 0; k < 11; k++) tick();
        chk("flush_pre_busy", {31'b0, busy}, 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_busy", {31'b0, busy}, 32'd0);
        seen_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (done) seen_done = 1'b1;
            tick();
        end
        chk("flush_no_done", {31'b0, seen_done}, 32'd0);
        chk("flush_hi", hi, 32'h12345678);
        chk("flush_lo", lo, 32'h12345678);

        // Start while busy is ignored
        start = 1'b1; funct = 6'h1b; op_a = 32'd100; op_b = 32'd7;
        tick();
        funct = 6'h11; op_a = 32'hDEADBEEF;
        for (int k = 0; k < 5; k++) tick();
        chk("busy_start_hi", hi, 32'h12345678);
        start = 1'b0;
        cyc = -1;
        for (int k = 6; k <= 60; k++) begin
            tick();
            if (done) begin
                cyc = k;
                break;
            end
        end
        chk("busy_start_cyc", 32'(cyc), 32'd34);
        chk("busy_start_lo", lo, 32'd14);
        chk("busy_start_rem", hi, 32'd2);

        // Reset mid-RUN
        start = 1'b1; funct = 6'h18; op_a = 32'h7; op_b = 32'h9;
        tick();
        start = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", {31'b0, busy}, 32'd0);
        chk("rst_mid_done", {31'b0, done}, 32'd0);
        chk("rst_mid_illegal", {31'b0, illegal}, 32'd0);
        chk("rst_mid_hi", hi, 32'd0);
        chk("rst_mid_lo", lo, 32'd0);
        tick();
        rst_n = 1'b1;
        seen_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (done) seen_done = 1'b1;
        end
        chk("rst_mid_no_done", {31'b0, seen_done}, 32'd0);
        chk("rst_mid_lo_after", lo, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
